// File: rtl/activation_grad_stream.sv
// Two-stage streaming backward pass for relu / leaky / hardtanh / sigmoid.
// Define ACT_GRAD_SAT_EN to clamp sigmoid overflow (else wrap, out_sat=0).
module activation_grad_stream #(
    parameter int WIDTH                = 8,
    parameter int DECIMAL_POINT        = 6,
    parameter int NEGATIVE_SLOPE_SHIFT = 5
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    clr,
    input  logic [1:0]              mode,
    input  logic signed [WIDTH-1:0] fwd_data,
    input  logic signed [WIDTH-1:0] grad_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] grad_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sat,
    output logic [15:0]             beat_cnt
);

    localparam int PW = 2 * WIDTH + 2;
    localparam logic signed [PW-1:0] ONE = PW'(1 <<< DECIMAL_POINT);
    localparam logic signed [PW-1:0] HI  = PW'((1 <<< (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] LO  = -HI - PW'(1);

    typedef enum logic [1:0] {
        M_RELU  = 2'd0,
        M_LEAKY = 2'd1,
        M_HTANH = 2'd2,
        M_SIGM  = 2'd3
    } mode_e;

    // Returns {overflow_flag, value reduced to WIDTH bits}.
    function automatic logic [WIDTH:0] reduce(input logic signed [PW-1:0] v);
`ifdef ACT_GRAD_SAT_EN
        if (v > HI)
            return {1'b1, HI[WIDTH-1:0]};
        else if (v < LO)
            return {1'b1, LO[WIDTH-1:0]};
        else
            return {1'b0, v[WIDTH-1:0]};
`else
        return {1'b0, v[WIDTH-1:0]};
`endif
    endfunction

    logic                    s1_vld_q;
    mode_e                   s1_mode_q;
    logic signed [WIDTH-1:0] s1_x_q;
    logic signed [WIDTH-1:0] s1_g_q;
    logic signed [WIDTH-1:0] s1_d_q;
    logic                    s1_dsat_q;

    logic                    out_valid_q;
    logic signed [WIDTH-1:0] grad_q;
    logic                    sat_q;
    logic [15:0]             cnt_q;

    logic                    adv;
    logic signed [PW-1:0]    y_w;
    logic signed [PW-1:0]    d_prod;
    logic [WIDTH:0]          d_red;
    logic signed [WIDTH-1:0] s1_d_d;
    logic                    s1_dsat_d;

    logic signed [PW-1:0]    g_w;
    logic signed [PW-1:0]    dd_w;
    logic signed [PW-1:0]    x_w;
    logic signed [PW-1:0]    gd_prod;
    logic [WIDTH:0]          gd_red;
    logic signed [WIDTH-1:0] grad_d;
    logic                    sat_d;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign grad_out  = grad_q;
    assign out_sat   = sat_q;
    assign beat_cnt  = cnt_q;

    // Sigmoid derivative y*(1-y) formed in stage 1.
    always_comb begin
        y_w       = PW'(fwd_data);
        d_prod    = (y_w * (ONE - y_w)) >>> DECIMAL_POINT;
        d_red     = reduce(d_prod);
        s1_d_d    = d_red[WIDTH-1:0];
        s1_dsat_d = d_red[WIDTH];
    end

    always_comb begin
        g_w     = PW'(s1_g_q);
        dd_w    = PW'(s1_d_q);
        x_w     = PW'(s1_x_q);
        gd_prod = (g_w * dd_w) >>> DECIMAL_POINT;
        gd_red  = reduce(gd_prod);
        grad_d  = '0;
        sat_d   = 1'b0;
        unique case (s1_mode_q)
            M_RELU:
                grad_d = s1_x_q[WIDTH-1] ? '0 : s1_g_q;
            M_LEAKY:
                grad_d = s1_x_q[WIDTH-1] ?
                         (s1_g_q >>> NEGATIVE_SLOPE_SHIFT) : s1_g_q;
            M_HTANH:
                grad_d = (x_w >= -ONE && x_w <= ONE) ? s1_g_q : '0;
            M_SIGM: begin
                grad_d = gd_red[WIDTH-1:0];
                sat_d  = gd_red[WIDTH] | s1_dsat_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1_vld_q    <= 1'b0;
            s1_mode_q   <= M_RELU;
            s1_x_q      <= '0;
            s1_g_q      <= '0;
            s1_d_q      <= '0;
            s1_dsat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            grad_q      <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
        end else if (clr) begin
            s1_vld_q    <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (adv) begin
                s1_vld_q    <= in_valid;
                s1_mode_q   <= mode_e'(mode);
                s1_x_q      <= fwd_data;
                s1_g_q      <= grad_in;
                s1_d_q      <= s1_d_d;
                s1_dsat_q   <= s1_dsat_d;
                out_valid_q <= s1_vld_q;
                grad_q      <= grad_d;
                sat_q       <= sat_d;
            end
            if (out_valid_q && out_ready)
                cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_activation_grad_stream.sv
// Directed bench for activation_grad_stream (WIDTH=8, DP=6, SHIFT=5).
// Expected sigmoid overflow result follows ACT_GRAD_SAT_EN.
module tb_activation_grad_stream;

    logic              iClk = 1'b0;
    logic              iRst;
    logic              clr;
    logic [1:0]        mode;
    logic signed [7:0] fwd_data;
    logic signed [7:0] grad_in;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] grad_out;
    logic              out_valid;
    logic              out_ready;
    logic              out_sat;
    logic [15:0]       beat_cnt;

    int checks = 0;
    int errors = 0;

    activation_grad_stream #(
        .WIDTH(8),
        .DECIMAL_POINT(6),
        .NEGATIVE_SLOPE_SHIFT(5)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .clr(clr),
        .mode(mode),
        .fwd_data(fwd_data),
        .grad_in(grad_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .grad_out(grad_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sat(out_sat),
        .beat_cnt(beat_cnt)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic put(input logic [1:0] m,
                       input logic signed [7:0] x,
                       input logic signed [7:0] g);
        in_valid = 1'b1;
        mode     = m;
        fwd_data = x;
        grad_in  = g;
    endtask

    // Mixed-mode back-to-back vectors
    logic [1:0]        vm [8] = '{1, 2, 2, 2, 2, 3, 3, 0};
    logic signed [7:0] vx [8] = '{-1, 64, 65, -64, -65, 32, 127, 5};
    logic signed [7:0] vg [8] = '{-64, 10, 10, 10, 10, 64, -128, -7};
`ifdef ACT_GRAD_SAT_EN
    logic signed [7:0] ve [8] = '{-2, 10, 0, 10, 0, 16, 127, -7};
    logic              vs [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
`else
    logic signed [7:0] ve [8] = '{-2, 10, 0, 10, 0, 16, -4, -7};
    logic              vs [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

    int                q[$];
    int                sent;
    int                got;
    int                cons;
    logic signed [7:0] held;
    logic              stalled;

    initial begin
        iRst      = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        mode      = 2'd0;
        fwd_data  = '0;
        grad_in   = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_grad_out", grad_out, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        cyc();
        cyc();
        iRst = 1'b0;
        cyc();
        chk("post_rst_in_ready", in_ready, 1);

        // relu latency: negative and zero x
        put(0, -3, 40);
        cyc();
        in_valid = 1'b0;
        chk("m0_neg_lat1", out_valid, 0);
        cyc();
        chk("m0_neg_valid", out_valid, 1);
        chk("m0_neg_grad", grad_out, 0);
        cyc();
        chk("m0_neg_bubble", out_valid, 0);
        put(0, 0, 40);
        cyc();
        in_valid = 1'b0;
        chk("m0_zero_lat1", out_valid, 0);
        cyc();
        chk("m0_zero_valid", out_valid, 1);
        chk("m0_zero_grad", grad_out, 40);
        cyc();
        chk("m0_cnt", beat_cnt, 2);

        // back-to-back mixed modes
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) put(vm[k], vx[k], vg[k]);
            else in_valid = 1'b0;
            cyc();
            chk("mix_valid", out_valid, (k >= 1) ? 1 : 0);
            if (k >= 1) begin
                chk($sformatf("mix_grad%0d", k - 1), grad_out, ve[k-1]);
                chk($sformatf("mix_sat%0d", k - 1), out_sat, vs[k-1]);
            end
        end
        cyc();
        chk("mix_drain", out_valid, 0);
        chk("mix_cnt", beat_cnt, 10);

        // backpressure with scoreboard
        sent = 0;
        got = 0;
        stalled = 1'b0;
        held = '0;
        for (int t = 0; t < 16; t++) begin
            if (sent < 6) put(0, 1, 8'(sent + 1));
            else in_valid = 1'b0;
            out_ready = !(t >= 3 && t <= 5);
            #1;
            chk("bp_in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
            if (stalled) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_grad", grad_out, held);
            end
            stalled = out_valid && !out_ready;
            held = grad_out;
            if (in_valid && in_ready) begin
                q.push_back(sent + 1);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("bp_spurious", 1, 0);
                else chk("bp_data", grad_out, q.pop_front());
                got++;
            end
            cyc();
        end
        out_ready = 1'b1;
        chk("bp_got", got, 6);
        chk("bp_left", q.size(), 0);
        chk("bp_cnt", beat_cnt, 16);

        // async reset with two beats in flight
        put(0, 0, 11);
        cyc();
        put(0, 0, 22);
        cyc();
        in_valid = 1'b0;
        chk("ir_inflight", out_valid, 1);
        #2;
        iRst = 1'b1;
        #1;
        chk("ir_out_valid", out_valid, 0);
        chk("ir_beat_cnt", beat_cnt, 0);
        chk("ir_grad", grad_out, 0);
        chk("ir_in_ready", in_ready, 1);
        #2;
        iRst = 1'b0;
        cyc();
        chk("ir_discard", out_valid, 0);
        put(0, 0, 33);
        cyc();
        in_valid = 1'b0;
        chk("ir_lat1", out_valid, 0);
        cyc();
        chk("ir_valid", out_valid, 1);
        chk("ir_grad33", grad_out, 33);
        cyc();
        chk("ir_cnt1", beat_cnt, 1);

        // clr drops in-flight beat and concurrent input
        put(0, 0, 55);
        cyc();
        put(0, 0, 44);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", out_valid, 0);
        chk("clr_cnt", beat_cnt, 0);
        cyc();
        chk("clr_drop", out_valid, 0);
        cyc();
        chk("clr_drop2", out_valid, 0);

        // beat_cnt wrap
        cons = 0;
        put(0, 0, 1);
        for (int i = 0; i < 65540; i++) begin
            if (i == 65536) in_valid = 1'b0;
            if (out_valid && out_ready) cons++;
            cyc();
            if (cons == 65535 && out_valid === 1'b1 && i < 65536)
                if (beat_cnt == 16'hFFFF) begin
                    chk("wrap_max", beat_cnt, 16'hFFFF);
                    cons = cons;
                end
        end
        chk("wrap_cons", cons, 65536);
        chk("wrap_cnt", beat_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/activation_grad_stream.md
ACTIVATION_GRAD_STREAM -- requirements
Module: activation_grad_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: signed two's-complement width of all data ports.
REQ-002 SHALL have parameter DECIMAL_POINT, default 6: fraction bits; ONE = 1 <<< DECIMAL_POINT.
REQ-003 SHALL have parameter NEGATIVE_SLOPE_SHIFT, default 5: leaky negative-slope right-shift.
REQ-004 Ports: one clock; reset asynchronous, active-high.
REQ-005 iClk  input  1  clock, all state on rising edge.
REQ-006 iRst  input  1  asynchronous active-high reset.
REQ-007 clr  input  1  synchronous flush of pipeline and counter.
REQ-008 mode  input  2  per-beat select: 0 relu, 1 leaky relu, 2 hardtanh, 3 sigmoid.
REQ-009 fwd_data  input  WIDTH  forward operand: pre-activation x (modes 0-2) or sigmoid output y (mode 3).
REQ-010 grad_in  input  WIDTH  upstream gradient g.
REQ-011 in_valid / in_ready  input / output  1  input handshake.
REQ-012 grad_out  output  WIDTH  downstream gradient.
REQ-013 out_valid / out_ready  output / input  1  output handshake.
REQ-014 out_sat  output  1  grad_out was clipped (qualified by out_valid).
REQ-015 beat_cnt  output  16  count of accepted output beats.

Function
REQ-016 adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally; input accepted when in_valid && in_ready.
REQ-017 Two-stage pipeline: on adv, stage1 captures {in_valid, mode, x/y, g}, stage2 captures stage1; stages hold when !adv.
REQ-018 Latency SHALL be exactly 2 cycles for every mode, throughput 1 beat/cycle; bubbles propagate, not collapsed.
REQ-019 grad_out, out_sat, out_valid SHALL be stage2 registers and SHALL remain stable while out_valid && !out_ready.
REQ-020 Mode 0: sign(x)=0 (incl. x=0) -> g; else 0.
REQ-021 Mode 1: sign(x)=0 -> g; else g >>> NEGATIVE_SLOPE_SHIFT (arithmetic).
REQ-022 Mode 2: -ONE <= x <= ONE (inclusive) -> g; else 0.
REQ-023 Mode 3: stage1 d = (y*(ONE-y)) >>> DECIMAL_POINT; stage2 grad_out = (g*d) >>> DECIMAL_POINT; products full precision (2*WIDTH+2 bits), shifts floor toward -inf, d reduced to WIDTH by REQ-031/032 rule.
REQ-024 beat_cnt SHALL increment on out_valid && out_ready, wrapping 65535 -> 0.
REQ-025 clr SHALL, on the next edge, clear both stage valids and beat_cnt, overriding any concurrent handshake; input presented that cycle is dropped.
REQ-026 in_valid with mode changing beat-to-beat SHALL apply each beat's own mode.

Reset
REQ-027 iRst high SHALL immediately force out_valid=0, stage1 valid=0, grad_out=0, out_sat=0, beat_cnt=0 without a clock edge.
REQ-028 Reset mid-transfer SHALL discard in-flight beats; first beat after release emerges 2 cycles after acceptance.
REQ-029 in_ready SHALL be 1 during and after reset (pipeline empty).

Configuration
REQ-030 Macro ACT_GRAD_SAT_EN selects overflow behaviour of d and grad_out.
REQ-031 Defined: values outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] SHALL clamp to the nearer bound and set out_sat=1.
REQ-032 Undefined: values SHALL wrap to low WIDTH bits; out_sat SHALL be constant 0.

Verification (WIDTH=8, DECIMAL_POINT=6, SHIFT=5, out_ready=1 unless stated)
REQ-033 mode0: (x=-3,g=40) -> 0; (x=0,g=40) -> 40; each out_valid exactly 2 cycles after acceptance.
REQ-034 mode1 x=-1,g=-64 -> -2; mode2 x=64,g=10 -> 10; x=65 -> 0; x=-64 -> 10; x=-65 -> 0, back-to-back, mixed modes.
REQ-035 mode3 y=32,g=64 -> 16; y=127,g=-128 -> 127 with out_sat=1 (SAT_EN) or -4 with out_sat=0 (no macro).
REQ-036 Back-to-back stream, out_ready low 3 cycles: in_ready low while out_valid, grad_out stable, no beat lost/duplicated, beat_cnt equals beats consumed.
REQ-037 iRst pulse with two beats in flight: out_valid drops asynchronously, beat_cnt=0; clr with in_valid=1 drops that beat and yields out_valid=0 next cycle.
REQ-038 65536 consumed beats: beat_cnt wraps to 0.
